// File: rtl/alu_result_sel_pipe.sv
// One-hot ALU result select with a single registered valid/ready output stage.
// Optional illegal-select counter on err_cnt when ALU_SEL_ERRCNT_EN is defined.
module alu_result_sel_pipe #(
  parameter int WIDTH     = 16,
  parameter int NOPS      = 12,
  parameter int CLEAR_IDX = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NOPS*WIDTH-1:0] op_res,
  input  logic [NOPS-1:0]       sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  zero,
  output logic                  neg,
  output logic                  op_err
`ifdef ALU_SEL_ERRCNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  logic             seen;
  logic             multi;
  logic             legal;
  logic [WIDTH-1:0] pick;
  logic [WIDTH-1:0] nxt;
  logic             accept;

  // Legality is decided before the mux output is used, so a
  // malformed select can never OR channels together.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    pick  = '0;
    for (int i = 0; i < NOPS; i++) begin
      if (sel[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        if (i != CLEAR_IDX)
          pick = op_res[i*WIDTH +: WIDTH];
      end
    end
    legal = seen & ~multi;
    nxt   = legal ? pick : '0;
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res       <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      op_err    <= 1'b0;
    end else if (accept) begin
      res       <= nxt;
      out_valid <= 1'b1;
      zero      <= (nxt == '0);
      neg       <= nxt[WIDTH-1];
      op_err    <= ~legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_SEL_ERRCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_cnt <= '0;
    else if (accept && !legal && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Randomised and directed bench for alu_result_sel_pipe.
// Checks err_cnt as well when ALU_SEL_ERRCNT_EN is defined.
module tb_alu_result_sel_pipe;
  localparam int W = 16;
  localparam int N = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic [N*W-1:0] op_res;
  logic [N-1:0] sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] res;
  logic         out_valid;
  logic         out_ready;
  logic         zero;
  logic         neg;
  logic         op_err;
`ifdef ALU_SEL_ERRCNT_EN
  logic [7:0]   err_cnt;
`endif

  alu_result_sel_pipe #(.WIDTH(W), .NOPS(N), .CLEAR_IDX(11)) dut (
    .clk(clk), .reset(reset), .op_res(op_res), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .res(res),
    .out_valid(out_valid), .out_ready(out_ready), .zero(zero),
    .neg(neg), .op_err(op_err)
`ifdef ALU_SEL_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // reference state
  logic         m_valid;
  logic [W-1:0] m_res;
  logic         m_zero, m_neg, m_err;
  int           m_cnt;

  function automatic logic ref_err(input logic [N-1:0] s);
    return $countones(s) != 1;
  endfunction

  function automatic logic [W-1:0] ref_res(input logic [N-1:0] s,
                                           input logic [N*W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    if ($countones(s) == 1)
      for (int i = 0; i < N; i++)
        if (s[i] && i != 11) r = d[i*W +: W];
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_res = '0; m_zero = 0; m_neg = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] v);
    op_res[i*W +: W] = v;
  endtask

  // advance one clock, updating the reference with the inputs seen at the edge
  task automatic tick();
    if (in_valid && (!m_valid || out_ready)) begin
      m_valid = 1;
      m_res   = ref_res(sel, op_res);
      m_zero  = (m_res == 0);
      m_neg   = m_res[W-1];
      m_err   = ref_err(sel);
      if (m_err && m_cnt < 255) m_cnt++;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; out_ready = 0; sel = '0;
    op_res = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, res, zero, neg, op_err} !== {1'b0, 16'h0, 3'b000}) begin
      $display("FAIL reset_state got v=%b r=%h z=%b n=%b e=%b want all 0",
               out_valid, res, zero, neg, op_err);
    end else passed++;
    reset = 0;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else passed++;
`ifdef ALU_SEL_ERRCNT_EN
    total++;
    if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt);
    else passed++;
`endif
  endtask

  task automatic test_basic();
    in_valid = 1; sel = 12'h001; set_ch(0, 16'h00F0); out_ready = 1;
    tick();
    in_valid = 0;
    total++;
    if ({out_valid, res, zero, neg, op_err} !== {1'b1, 16'h00F0, 3'b000})
      $display("FAIL basic got v=%b r=%h z=%b n=%b e=%b want 1 00f0 0 0 0",
               out_valid, res, zero, neg, op_err);
    else passed++;
  endtask

  task automatic test_hold();
    in_valid = 1; sel = 12'h080; set_ch(7, 16'h8001); out_ready = 1;
    tick();
    out_ready = 0;
    set_ch(7, 16'h1234);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) $display("FAIL hold_in_ready c%0d got %b want 0", k, in_ready);
      else passed++;
      tick();
      total++;
      if ({out_valid, res, zero, neg, op_err} !== {1'b1, 16'h8001, 3'b010})
        $display("FAIL hold c%0d got v=%b r=%h n=%b want 1 8001 n=1", k, out_valid, res, neg);
      else passed++;
    end
    out_ready = 1; in_valid = 0;
    tick();
    total++;
    if ({out_valid, res, neg} !== {1'b0, 16'h8001, 1'b1})
      $display("FAIL drain got v=%b r=%h n=%b want 0 8001 1", out_valid, res, neg);
    else passed++;
  endtask

  task automatic test_clear();
    in_valid = 1; sel = 12'h800; set_ch(11, 16'hFFFF); out_ready = 1;
    tick();
    in_valid = 0;
    total++;
    if ({out_valid, res, zero, neg, op_err} !== {1'b1, 16'h0, 3'b100})
      $display("FAIL clear got v=%b r=%h z=%b n=%b e=%b want 1 0000 1 0 0",
               out_valid, res, zero, neg, op_err);
    else passed++;
  endtask

  task automatic test_illegal();
    logic [N-1:0] pats [2];
    reset = 1; #1; reset = 0; model_reset();
    pats[0] = 12'h000; pats[1] = 12'h300;
    for (int i = 0; i < N; i++) set_ch(i, 16'h5A5A + 16'(i));
    out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; sel = pats[k];
      tick();
      total++;
      if ({out_valid, res, zero, op_err} !== {1'b1, 16'h0, 1'b1, 1'b1})
        $display("FAIL illegal_%0d got r=%h z=%b e=%b want 0000 1 1", k, res, zero, op_err);
      else passed++;
    end
    in_valid = 0;
`ifdef ALU_SEL_ERRCNT_EN
    total++;
    if (err_cnt !== 8'd2) $display("FAIL err_cnt_two got %0d want 2", err_cnt);
    else passed++;
    in_valid = 1;
    for (int k = 0; k < 300; k++) begin
      sel = (k % 2 == 0) ? 12'h000 : 12'hC30;
      tick();
    end
    in_valid = 0;
    total++;
    if (err_cnt !== 8'd255) $display("FAIL err_cnt_sat got %0d want 255", err_cnt);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v [4];
    out_ready = 1;
    for (int k = 0; k < 4; k++) v[k] = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; sel = 12'(1 << k); set_ch(k, v[k]);
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready k%0d got %b want 1", k, in_ready);
      else passed++;
      tick();
      total++;
      if ({out_valid, res, op_err} !== {1'b1, v[k], 1'b0})
        $display("FAIL b2b k%0d got v=%b r=%h want 1 %h", k, out_valid, res, v[k]);
      else passed++;
    end
    in_valid = 0;
  endtask

  task automatic test_reset_mid_hold();
    in_valid = 1; sel = 12'h002; set_ch(1, 16'h9000); out_ready = 1;
    tick();
    in_valid = 0; out_ready = 0;
    tick();
    #2 reset = 1;
    #1;
    model_reset();
    total++;
    if ({out_valid, res, zero, neg, op_err} !== {1'b0, 16'h0, 3'b000})
      $display("FAIL mid_reset got v=%b r=%h z=%b n=%b e=%b want all 0",
               out_valid, res, zero, neg, op_err);
    else passed++;
    @(posedge clk); #1;
    reset = 0;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL mid_reset_in_ready got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) set_ch(i, 16'($urandom));
      if ($urandom_range(0, 9) == 0) set_ch($urandom_range(0, N - 1), 16'h0);
      r = $urandom_range(0, 9);
      if (r < 6)      sel = 12'(1 << $urandom_range(0, N - 1));
      else if (r < 7) sel = '0;
      else            sel = 12'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      total++;
      if (in_ready !== (!m_valid || out_ready))
        $display("FAIL rand_in_ready c%0d got %b want %b", c, in_ready, !m_valid || out_ready);
      else passed++;
      tick();
      total++;
      if ({out_valid, res, zero, neg, op_err} !== {m_valid, m_res, m_zero, m_neg, m_err})
        $display("FAIL rand c%0d got v=%b r=%h z=%b n=%b e=%b want %b %h %b %b %b",
                 c, out_valid, res, zero, neg, op_err,
                 m_valid, m_res, m_zero, m_neg, m_err);
      else passed++;
`ifdef ALU_SEL_ERRCNT_EN
      total++;
      if (err_cnt !== 8'(m_cnt)) $display("FAIL rand_err_cnt c%0d got %0d want %0d", c, err_cnt, m_cnt);
      else passed++;
`endif
    end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_clear();
    test_illegal();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
